fifo_level: RTL and testbench
=============================

// Module: fifo_level
// PURPOSE
// - Parametrised successor of the simple FIFO: single-clock, valid/ready on both sides.
// - Uses all DEPTH entries (extra pointer wrap bit), reports fill level and
//   programmable almost-full/almost-empty flags, and has a synchronous flush.
// - Sits between MCU bus masters and DMA/peripheral engines for rate decoupling.
// PARAMETERS
// - WIDTH     32  data word width, >=1
// - DEPTH     16  storage entries, power of two, >=2 (checked by elaboration assert)
// - AF_LEVEL  12  almost_full asserted when level >= AF_LEVEL (1..DEPTH)
// - AE_LEVEL  2   almost_empty asserted when level <= AE_LEVEL (0..DEPTH-1)
// PORTS
// - clk           in   1              single clock, all logic on rising edge
// - resetn        in   1              asynchronous reset, active-low
// - flush         in   1              synchronous discard of all contents
// - in_data       in   WIDTH          push data
// - in_valid      in   1              push request
// - in_ready      out  1              space available
// - out_data      out  WIDTH          head-of-queue data
// - out_valid     out  1              head valid
// - out_ready     in   1              pop request
// - level         out  $clog2(DEPTH)+1  entries held (0..DEPTH, +1 with FIFO_OUTREG_EN)
// - almost_full   out  1              level >= AF_LEVEL
// - almost_empty  out  1              level <= AE_LEVEL
// BEHAVIOUR
// - Reset (resetn=0, async): rd/wr pointers, level=0, in_ready=1, out_valid=0,
//   almost_full=0, almost_empty=1. Memory is not reset; out_data is don't-care while !out_valid.
// - Reset mid-operation drops all contents immediately; no partial transfer completes.
// - Pointers DEPTH_LOG2+1 bits: empty = ptrs equal; full = low bits equal, MSB differs.
// - push = in_valid & in_ready; pop = out_valid & out_ready. Transfer on clk edge.
// - in_ready = !full; out_valid = !empty. Both purely from registered state (no comb path
//   from in_valid to out_valid or from out_ready to in_ready).
// - Latency: pushed word visible at out_valid/out_data the cycle after the push edge.
// - Full: in_ready=0 even if pop in same cycle; push retried next cycle (no pass-through).
// - Empty: pop ignored; push and stalled pop give out_valid=1 next cycle.
// - Simultaneous push & pop (neither full nor empty): both pointers advance, level unchanged.
// - Pointer wrap: low bits roll DEPTH-1 -> 0, MSB toggles; order strictly FIFO across wraps.
// - level updated registered: +1 push only, -1 pop only, else held; never exceeds capacity.
// - almost_full/almost_empty registered, consistent with level in the same cycle.
// - flush=1: next cycle ptrs equal, level=0, out_valid=0; flush has priority over push/pop
//   in that cycle (concurrent push is discarded).
// CONFIGURATION
// - FIFO_OUTREG_EN defined: registered output stage after memory; out_data from flop.
//   Push-to-out_valid latency 2 cycles; capacity DEPTH+1; level includes output reg;
//   output reg refills on the pop edge when memory non-empty (full throughput sustained).
//   flush and reset also clear output reg valid.
// - FIFO_OUTREG_EN undefined: out_data = mem[rd_ptr] combinationally; capacity DEPTH;
//   latency 1 cycle.
// TESTING
// - Reset, idle: in_ready=1, out_valid=0, level=0, almost_empty=1, almost_full=0.
// - Push 16 words 0x100..0x10F (DEPTH=16), out_ready=0 -> in_ready=0 after 16th,
//   level=16, almost_full from level 12; 17th push held off; pop all -> 0x100..0x10F in order.
// - Fill to 16, drive in_valid & out_ready 1 cycle -> one pop, no push, level=15;
//   next cycle push accepted, level=16.
// - Steady push+pop for 40 cycles at level 5 -> level stays 5, data order kept across
//   2+ pointer wraps, no bubbles.
// - level=9, flush=1 with in_valid=1 -> next cycle level=0, out_valid=0, word not stored.
// - Deassert resetn mid-burst at level 7 -> out_valid=0, level=0 same cycle (async);
//   after release, first push 0xABCD pops as 0xABCD. Repeat all with FIFO_OUTREG_EN (cap 17).

Source files
------------

// File: rtl/fifo_level.sv
// Single-clock FIFO with fill level, almost-full/almost-empty flags and synchronous flush.
// Define FIFO_OUTREG_EN to add a registered output stage (capacity DEPTH+1, 2-cycle latency).
module fifo_level #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_level: DEPTH must be a power of two >= 2");
  end

  // Handshake: a word moves on a rising edge when valid and ready are both high
  // on that side; ready/valid are decoded from registered state only.
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              mem_empty;
  logic              mem_full;
  logic              push;
  logic              pop;
  logic              mem_rd;
  logic [LW-1:0]     level_q;
  logic [LW-1:0]     level_nxt;

  assign mem_empty = (wr_ptr == rd_ptr);
  assign mem_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = !mem_full;
  assign push      = in_valid && in_ready;

`ifdef FIFO_OUTREG_EN
  logic             oreg_valid;
  logic [WIDTH-1:0] oreg_data;

  // The output register refills on the same edge it is consumed, so throughput stays at one word per cycle.
  assign pop       = oreg_valid && out_ready;
  assign mem_rd    = !mem_empty && (!oreg_valid || out_ready);
  assign out_valid = oreg_valid;
  assign out_data  = oreg_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oreg_valid <= 1'b0;
    end else if (flush) begin
      oreg_valid <= 1'b0;
    end else if (mem_rd) begin
      oreg_valid <= 1'b1;
    end else if (pop) begin
      oreg_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_rd && !flush) begin
      oreg_data <= mem[rd_ptr[AW-1:0]];
    end
  end
`else
  assign pop       = !mem_empty && out_ready;
  assign mem_rd    = pop;
  assign out_valid = !mem_empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (mem_rd) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  // Level counts every held word, including the output register when present.
  always_comb begin
    level_nxt = level_q;
    if (flush) begin
      level_nxt = '0;
    end else if (push && !pop) begin
      level_nxt = level_q + LW'(1);
    end else if (pop && !push) begin
      level_nxt = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_q      <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      level_q      <= level_nxt;
      almost_full  <= (level_nxt >= LW'(AF_LEVEL));
      almost_empty <= (level_nxt <= LW'(AE_LEVEL));
    end
  end

  assign level = level_q;

endmodule

// File: tb/tb_fifo_level.sv
// Randomised and directed bench for fifo_level; the reference model is a queue of held words.
module tb_fifo_level;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;
`ifdef FIFO_OUTREG_EN
  localparam int CAP   = DEPTH + 1;
  localparam bit OREG  = 1'b1;
`else
  localparam int CAP   = DEPTH;
  localparam bit OREG  = 1'b0;
`endif

  logic                     clk;
  logic                     resetn;
  logic                     flush;
  logic [WIDTH-1:0]         in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   level;
  logic                     almost_full;
  logic                     almost_empty;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  fifo_level #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: model occupancy is the queue size
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
    end else begin
      chk("level", 32'(level), 32'(exp_q.size()));
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() < CAP));
      chk("almost_full", 32'(almost_full), 32'(exp_q.size() >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(exp_q.size() <= AE));
      if (!OREG || exp_q.size() != 1) begin
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_empty: got pop of 0x%0h expected no data at %0t", out_data, $time);
          end else begin
            chk("out_data", out_data, exp_q.pop_front());
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(in_data);
        end
      end
    end
  end

  // driver tasks
  task automatic drive(input logic iv, input logic [WIDTH-1:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic fill(input int n, input logic [WIDTH-1:0] base);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, base + WIDTH'(i), 1'b0, 1'b0);
    end
    idle();
  endtask

  task automatic drain();
    for (int i = 0; i < CAP + 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    idle();
  endtask

  initial begin
    resetn    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    resetn = 1'b1;
    idle();

    // fill to capacity, one extra push must be held off, then pop in order
    for (int i = 0; i < CAP; i++) begin
      drive(1'b1, 32'h100 + WIDTH'(i), 1'b0, 1'b0);
    end
    drive(1'b1, 32'h1FF, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("full_level", 32'(level), 32'(CAP));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_almost_full", 32'(almost_full), 32'd1);
    drain();
    @(negedge clk);
    chk("drained_level", 32'(level), 32'd0);

    // full with in_valid & out_ready: pop only, push taken next cycle
    fill(CAP, 32'h200);
    drive(1'b1, 32'h2AA, 1'b1, 1'b0);
    drive(1'b1, 32'h2AA, 1'b0, 1'b0);
    @(negedge clk);
    chk("fullpop_level", 32'(level), 32'(CAP - 1));
    chk("fullpop_in_ready", 32'(in_ready), 32'd1);
    idle();
    @(negedge clk);
    chk("refill_level", 32'(level), 32'(CAP));
    drain();

    // steady push+pop at level 5 across pointer wraps
    fill(5, 32'h300);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 32'h400 + WIDTH'(i), 1'b1, 1'b0);
      @(negedge clk);
      chk("steady_level", 32'(level), 32'd5);
      chk("steady_out_valid", 32'(out_valid), 32'd1);
    end
    idle();
    drain();

    // flush at level 9 with a concurrent push
    fill(9, 32'h500);
    drive(1'b1, 32'hDEAD, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 32'h55, 1'b0, 1'b0);
    idle();
    drain();

    // async reset mid-burst at level 7
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'h600 + WIDTH'(i), 1'b0, 1'b0);
    end
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    resetn   = 1'b1;
    drive(1'b1, 32'hABCD, 1'b0, 1'b0);
    idle();
    drain();

    // random traffic with occasional flush
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 39) == 0));
    end
    idle();
    drain();
    @(negedge clk);
    chk("end_level", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
